// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes M-stage memory ops, runs one bus
// transaction per access, checks alignment and returns extended load data.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic              flushM,
  input  logic              pipe_stall,
  input  logic [5:0]        opM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  output logic              adel_rdM,
  output logic              adesM,
  output logic [ADDR_W-1:0] bad_addrM,
  output logic              stall_memM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;

  logic is_load, is_store, is_byte, is_half, is_word;
  logic misaligned, go;
  logic req_c, stall_c, latch_c;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_ext;

  // Opcode decode and alignment checks
  always_comb begin
    is_byte  = (opM == OP_LB) || (opM == OP_LBU) || (opM == OP_SB);
    is_half  = (opM == OP_LH) || (opM == OP_LHU) || (opM == OP_SH);
    is_word  = (opM == OP_LW) || (opM == OP_SW);
    is_store = (opM == OP_SB) || (opM == OP_SH) || (opM == OP_SW);
    is_load  = (opM == OP_LB) || (opM == OP_LBU) || (opM == OP_LH) ||
               (opM == OP_LHU) || (opM == OP_LW);
    misaligned = (is_half && aluoutM[0]) || (is_word && (aluoutM[1:0] != 2'b00));
    adel_rdM   = validM && is_load && misaligned;
    adesM      = validM && is_store && misaligned;
    bad_addrM  = (adel_rdM || adesM) ? aluoutM : '0;
    go         = validM && (is_load || is_store) && !misaligned && !flushM;
  end

  // Lane select and extension use the op/lane captured at issue
  always_comb begin
    case (lane_q)
      2'd0:    sel_byte = data_rdata[7:0];
      2'd1:    sel_byte = data_rdata[15:8];
      2'd2:    sel_byte = data_rdata[23:16];
      default: sel_byte = data_rdata[31:24];
    endcase
    sel_half = lane_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_ext = {24'd0, sel_byte};
      OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_ext = {16'd0, sel_half};
      default: load_ext = data_rdata;
    endcase
  end

  // Transaction FSM
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    op_d       = op_q;
    lane_d     = lane_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    latch_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          op_d    = opM;
          lane_d  = aluoutM[1:0];
          state_d = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_addr_ok) begin
          state_d = S_WAIT;
        end else if (flushM) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (data_data_ok) begin
          latch_c = 1'b1;
          state_d = S_DONE;
        end else if (flushM) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!pipe_stall || flushM) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        stall_c = go;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Stores complete through the same path but never touch readdata
    if (latch_c && (op_q != OP_SB) && (op_q != OP_SH) && (op_q != OP_SW)) begin
      readdata_d = load_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      readdata_q <= '0;
      op_q       <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
    end
  end

  // Request/stall are forced low while reset is held, even with a go pending
  assign readdataM  = readdata_q;
  assign data_req   = rst && req_c;
  assign stall_memM = rst && stall_c;

  // Bus fields follow the (stalled, hence stable) M-stage inputs while requesting
  always_comb begin
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_wstrb = 4'b0000;
    data_addr  = '0;
    data_wdata = '0;
    if (data_req) begin
      data_wr   = is_store;
      data_addr = aluoutM;
      if (is_half) begin
        data_size = 2'd1;
      end else if (is_word) begin
        data_size = 2'd2;
      end
      case (opM)
        OP_SB: begin
          data_wstrb = 4'b0001 << aluoutM[1:0];
          data_wdata = {4{writedataM[7:0]}};
        end
        OP_SH: begin
          data_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{writedataM[15:0]}};
        end
        OP_SW: begin
          data_wstrb = 4'b1111;
          data_wdata = writedataM;
        end
        default: begin
          data_wstrb = 4'b0000;
          data_wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed protocol scenarios plus random ops,
// checked against an arithmetic model of the load/store rules.
module tb_mem_access_unit;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, flushM, pipe_stall;
  logic [5:0]  opM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM, bad_addrM, data_addr, data_wdata, data_rdata;
  logic        adel_rdM, adesM, stall_memM, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .validM(validM), .flushM(flushM), .pipe_stall(pipe_stall),
    .opM(opM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .adel_rdM(adel_rdM), .adesM(adesM), .bad_addrM(bad_addrM), .stall_memM(stall_memM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  function automatic int op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [5:0] op, input logic [31:0] addr);
    int s = op_size(op);
    if (!op_store(op)) return 4'd0;
    return 4'(((1 << s) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] wd);
    int s = op_size(op);
    if (s == 1) return 32'(wd[7:0]) * 32'h01010101;
    if (s == 2) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int s = op_size(op);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
    v = (rdata >> (8 * int'(addr[1:0]))) & mask;
    if (op_signed(op) && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Aligned memory op: addr_ok after alat cycles, data_ok dlat cycles later,
  // then hold cycles of pipe_stall in DONE before the pipeline advances.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int alat, input int dlat, input int hold);
    int total = alat + dlat;
    int s = op_size(op);
    validM = 1'b1; opM = op; aluoutM = addr; writedataM = wd;
    for (int c = 0; c <= total; c++) begin
      data_addr_ok = (c == alat);
      data_data_ok = (c == total);
      data_rdata   = (c == total) ? rdata : $urandom();
      @(negedge clk);
      chk("stall_busy", 32'(stall_memM), 32'd1);
      chk("req_phase", 32'(data_req), 32'(c <= alat));
      if (c == 0 || c == alat) begin
        chk("bus_addr", data_addr, addr);
        chk("bus_wr", 32'(data_wr), 32'(op_store(op)));
        chk("bus_size", 32'(data_size), (s == 1) ? 32'd0 : (s == 2) ? 32'd1 : 32'd2);
        chk("bus_wstrb", 32'(data_wstrb), 32'(exp_strb(op, addr)));
        if (op_store(op)) chk("bus_wdata", data_wdata, exp_wdata(op, wd));
        chk("no_adel", 32'(adel_rdM), 32'd0);
        chk("no_bad", bad_addrM, 32'd0);
      end
      step();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom();
    if (!op_store(op)) exp_rd = exp_load(op, addr, rdata);
    pipe_stall = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("done_hold_stall", 32'(stall_memM), 32'd0);
      chk("done_hold_rd", readdataM, exp_rd);
      step();
    end
    pipe_stall = 1'b0;
    @(negedge clk);
    chk("done_stall", 32'(stall_memM), 32'd0);
    chk("done_req", 32'(data_req), 32'd0);
    chk("done_rd", readdataM, exp_rd);
    step();
    validM = 1'b0; opM = 6'd0;
  endtask

  task automatic run_any(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int alat, input int dlat, input int hold);
    int s = op_size(op);
    if (s != 0 && (int'(addr[1:0]) % s) == 0) begin
      run_op(op, addr, wd, rdata, alat, dlat, hold);
    end else begin
      validM = 1'b1; opM = op; aluoutM = addr; writedataM = wd;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        chk("err_adel", 32'(adel_rdM), 32'(s != 0 && !op_store(op)));
        chk("err_ades", 32'(adesM), 32'(s != 0 && op_store(op)));
        chk("err_bad", bad_addrM, (s != 0) ? addr : 32'd0);
        chk("err_req", 32'(data_req), 32'd0);
        chk("err_stall", 32'(stall_memM), 32'd0);
        step();
      end
      validM = 1'b0; opM = 6'd0;
    end
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'b000000, 6'b100010};
    rst = 1'b0; validM = 1'b1; flushM = 1'b0; pipe_stall = 1'b0;
    opM = OP_LW; aluoutM = 32'h1000; writedataM = 32'd0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stall_memM), 32'd0);
    chk("rst_rd", readdataM, 32'd0);
    validM = 1'b0; rst = 1'b1;
    step();

    run_op(OP_LW, 32'h1000, 32'd0, 32'hDEADBEEF, 0, 1, 0);
    chk("lw_lit", readdataM, 32'hDEADBEEF);
    run_op(OP_LB, 32'h1003, 32'd0, 32'h80FF_0000, 0, 1, 0);
    chk("lb_lit", readdataM, 32'hFFFFFF80);
    run_op(OP_LBU, 32'h1003, 32'd0, 32'h80FF_0000, 1, 2, 0);
    chk("lbu_lit", readdataM, 32'h00000080);
    run_op(OP_LH, 32'h1002, 32'd0, 32'h80FF_0000, 0, 1, 2);
    chk("lh_lit", readdataM, 32'hFFFF80FF);
    run_op(OP_SB, 32'h2001, 32'h123456AB, 32'h0, 0, 1, 0);
    run_op(OP_SH, 32'h2002, 32'h0000BEEF, 32'h0, 2, 1, 1);
    chk("store_keeps_rd", readdataM, 32'hFFFF80FF);
    run_any(OP_LW, 32'h3002, 32'd0, 32'd0, 0, 1, 0);
    run_any(OP_SH, 32'h3001, 32'd0, 32'd0, 0, 1, 0);

    // Flush while waiting for data: late data is drained and dropped
    validM = 1'b1; opM = OP_LW; aluoutM = 32'h4000;
    for (int c = 0; c < 4; c++) begin
      data_addr_ok = (c == 3);
      @(negedge clk);
      chk("fl_req", 32'(data_req), 32'd1);
      chk("fl_stall", 32'(stall_memM), 32'd1);
      step();
    end
    data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    chk("fl_wait_req", 32'(data_req), 32'd0);
    chk("fl_wait_stall", 32'(stall_memM), 32'd1);
    step();
    flushM = 1'b0; validM = 1'b0;
    @(negedge clk);
    chk("drain_bubble_stall", 32'(stall_memM), 32'd0);
    step();
    validM = 1'b1; aluoutM = 32'h5004;
    @(negedge clk);
    chk("drain_go_stall", 32'(stall_memM), 32'd1);
    chk("drain_go_req", 32'(data_req), 32'd0);
    step();
    data_data_ok = 1'b1; data_rdata = 32'hBADBAD00;
    @(negedge clk);
    chk("drain_ok_stall", 32'(stall_memM), 32'd1);
    chk("drain_ok_req", 32'(data_req), 32'd0);
    step();
    data_data_ok = 1'b0;
    chk("drain_rd_kept", readdataM, exp_rd);
    run_op(OP_LW, 32'h5004, 32'd0, 32'h13579BDF, 0, 1, 0);

    // Reset asserted mid-transaction
    validM = 1'b1; opM = OP_LW; aluoutM = 32'h6000; data_addr_ok = 1'b1;
    @(negedge clk);
    chk("rw_req", 32'(data_req), 32'd1);
    step();
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", 32'(stall_memM), 32'd1);
    #2 rst = 1'b0;
    #1;
    exp_rd = 32'd0;
    chk("rw_req0", 32'(data_req), 32'd0);
    chk("rw_stall0", 32'(stall_memM), 32'd0);
    chk("rw_rd0", readdataM, 32'd0);
    chk("rw_addr0", data_addr, 32'd0);
    validM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    run_op(OP_LHU, 32'h7002, 32'd0, 32'h8001_2345, 1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      int s;
      op = ops[$urandom_range(0, 9)];
      s = op_size(op);
      addr = $urandom();
      if (s > 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
      run_any(op, addr, $urandom(), $urandom(), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the pipeline M stage and the data-side SRAM-like bus.
- Inputs: opM, aluoutM (address) and writedataM from the datapath.
- Drives: one bus transaction per load/store, with byte strobes, store-data replication and address-error detection.
- Returns extended load data as readdataM, plus adel_rdM/adesM, and stalls the pipeline until the bus completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- validM  in  1  M-stage instruction valid (not a bubble)
- flushM  in  1  M stage flushed by exception/eret this cycle
- pipe_stall  in  1  stall from other sources; pipeline does not advance
- opM  in  6  opcode of M-stage instruction
- aluoutM  in  32  effective address
- writedataM  in  32  store source register value
- readdataM  out  32  extended load result, registered
- adel_rdM  out  1  load address error
- adesM  out  1  store address error
- bad_addrM  out  32  faulting address
- stall_memM  out  1  memory stall request to hazard unit
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb  out  4  byte write strobes
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  data phase complete

Behaviour:
- Opcodes: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011. Any other opcode is not a memory op.
- Alignment (combinational):
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - adel_rdM = validM & load & misaligned; adesM = validM & store & misaligned.
  - bad_addrM = aluoutM when either error is set, else 0.
  - A misaligned op never issues a request.
- go = validM & memop & ~misaligned & ~flushM.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE: when go, move to REQ. If data_addr_ok is already high in that cycle, the request is accepted and the FSM goes directly to WAIT; data_req is driven combinationally high in IDLE while go.
  - REQ: data_req=1. data_addr_ok -> WAIT. flushM with no addr_ok -> IDLE; the request is withdrawn, which the bus permits before addr_ok.
  - WAIT: data_req=0. data_data_ok -> DONE, and readdataM is latched. flushM -> DRAIN.
  - DONE: stall_memM=0. If ~pipe_stall | flushM -> IDLE; otherwise hold and keep readdataM stable.
  - DRAIN: wait for data_data_ok and discard data, then -> IDLE. A new go seen in DRAIN is held off: stall_memM=1 until IDLE.
- stall_memM = (IDLE & go) | REQ | WAIT | (DRAIN & go). It is never asserted in DONE. data_data_ok in the same cycle does not drop stall until DONE.
- Latency: minimum 2 cycles from go to DONE (addr_ok in the go cycle, data_ok the next cycle).
- Bus fields are held constant from go until addr_ok:
  - data_addr = aluoutM.
  - data_wr = store.
  - data_size: byte ops 0, half ops 1, word ops 2.
- Write strobes (addr[1:0] selects the lane, little-endian):
  - SB: wstrb = 0001 << addr[1:0].
  - SH: wstrb = 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Store data: SB wdata = {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
- Load extension (lane selected by addr[1:0]):
  - LB/LBU sign/zero-extend the selected byte.
  - LH/LHU sign/zero-extend the selected half.
  - LW passes the word through.
- Stores complete on data_ok exactly like loads; readdataM is not updated for stores.
- Reset (rst=0, asynchronous): state IDLE; readdataM=0; data_req=0; stall_memM=0. A transaction in flight at reset is abandoned, and the bus is reset by the same rst.
- Simultaneous flushM and go in IDLE: no request is issued.

Test Plan:
- LW 0x1000, addr_ok in the same cycle, data_ok 1 cycle later with rdata 0xDEADBEEF -> stall high for 2 cycles, readdataM=0xDEADBEEF, size=2.
- LB 0x1003, rdata 0x80FF_0000 -> readdataM=0xFFFFFF80. LBU at the same address -> 0x00000080. LH 0x1002 -> 0xFFFF80FF.
- SB 0x2001, writedataM 0x123456AB -> wstrb=0010, wdata=0xABABABAB, wr=1. SH 0x2002, wd 0x0000BEEF -> wstrb=1100, wdata=0xBEEFBEEF.
- LW 0x3002 -> adel_rdM=1, bad_addrM=0x3002, data_req never asserted. SH 0x3001 -> adesM=1.
- LW with addr_ok delayed 3 cycles, flushM pulsed in WAIT -> DRAIN; a late data_ok is discarded, readdataM unchanged; a new LW issued after the drain completes correctly.
- rst pulled low while in WAIT -> all outputs 0 immediately. DONE with pipe_stall=1 for 2 cycles -> readdataM held, stall_memM=0.
